// File: rtl/fdiv_iter.sv
// Iterative single-precision divider, y = x1 / x2.
// Denormal operands are treated as zero, the mantissa is truncated, and results
// outside the normal range saturate to signed zero or signed infinity.
// Restoring division produces one quotient bit per cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// CALC  | restoring division, one quotient bit per cycle (cnt 24 down to 0)
// NORM  | normalise the quotient, build the exponent, saturate, register y
// DONE  | result presented, waiting for out_ready_i
module fdiv_iter #(
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] y_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [24:0]        r_q, r_d;
    logic [23:0]        d_q, d_d;
    logic [24:0]        q_q, q_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  ediff_q, ediff_d;
    logic               s_q, s_d;
    logic [31:0]        y_q, y_d;

    logic [7:0]         e1, e2;
    logic               x1_zero, x2_zero, x1_inf, x2_inf;
    logic               sign_in;
    logic               special;
    logic [31:0]        special_y;
    logic [24:0]        d_ext;
    logic signed [9:0]  e_norm;
    logic [22:0]        mant_norm;

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign y_o         = y_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            ediff_q <= '0;
            s_q     <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ediff_q <= ediff_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    // Operand classification; exponent 255 is always infinity, NaN payloads ignored.
    always_comb begin
        e1        = x1_i[30:23];
        e2        = x2_i[30:23];
        x1_zero   = (e1 == 8'h00);
        x2_zero   = (e2 == 8'h00);
        x1_inf    = (e1 == 8'hFF);
        x2_inf    = (e2 == 8'hFF);
        sign_in   = x1_i[31] ^ x2_i[31];
        special   = 1'b1;
        special_y = '0;
        if ((x1_zero && x2_zero) || (x1_inf && x2_inf)) begin
            special_y = NAN_VALUE;
        end else if (x2_zero || x1_inf) begin
            special_y = {sign_in, 8'hFF, 23'd0};
        end else if (x1_zero || x2_inf) begin
            special_y = {sign_in, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Quotient normalisation: exponent bias depends on whether q[24] is set.
    always_comb begin
        d_ext     = {1'b0, d_q};
        e_norm    = ediff_q + (q_q[24] ? 10'sd127 : 10'sd126);
        mant_norm = q_q[24] ? q_q[23:1] : q_q[22:0];
    end

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ediff_d = ediff_q;
        s_d     = s_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    s_d = sign_in;
                    if (special) begin
                        y_d     = special_y;
                        state_d = DONE;
                    end else begin
                        r_d     = {2'b01, x1_i[22:0]};
                        d_d     = {1'b1, x2_i[22:0]};
                        q_d     = '0;
                        cnt_d   = 5'd24;
                        ediff_d = $signed({2'b00, e1}) - $signed({2'b00, e2});
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (r_q >= d_ext) begin
                    q_d = q_q | (25'd1 << cnt_q);
                    r_d = (r_q - d_ext) << 1;
                end else begin
                    r_d = r_q << 1;
                end
                if (cnt_q == 5'd0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            NORM: begin
                if (e_norm >= 10'sd255) begin
                    y_d = {s_q, 8'hFF, 23'd0};
                end else if (e_norm <= 10'sd0) begin
                    y_d = {s_q, 31'd0};
                end else begin
                    y_d = {s_q, e_norm[7:0], mant_norm};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
